// File: rtl/m_dram_tester.sv
`default_nettype none
// ============================================================================
// Module : m_dram_tester
// Brief  : MIG app-interface pattern writer / read-verifier with error count,
//          first-error address and read-data checksum.
// Rev    : 1.0  initial release
// ============================================================================
module m_dram_tester #(
  parameter int ADDR_W  = 27,
  parameter int DATA_W  = 128,
  parameter int STEP    = 8,
  parameter int MAX_OUT = 4
) (
  input  logic                  w_clk,
  input  logic                  w_rst,
  input  logic                  w_calib,
  input  logic                  w_start,
  input  logic [1:0]            w_mode,
  input  logic [ADDR_W-1:0]     w_base,
  input  logic [23:0]           w_count,
  input  logic [31:0]           w_seed,
  output logic [ADDR_W-1:0]     r_app_addr,
  output logic [2:0]            r_app_cmd,
  output logic                  r_app_en,
  output logic [DATA_W-1:0]     r_app_wdf_data,
  output logic                  r_app_wdf_wren,
  output logic                  r_app_wdf_end,
  output logic [DATA_W/8-1:0]   r_app_wdf_mask,
  input  logic                  w_app_rdy,
  input  logic                  w_app_wdf_rdy,
  input  logic                  w_app_rd_data_valid,
  input  logic [DATA_W-1:0]     w_app_rd_data,
  output logic                  r_busy,
  output logic                  r_done,
  output logic [31:0]           r_err_cnt,
  output logic [ADDR_W-1:0]     r_first_err_addr,
  output logic [31:0]           r_sum
);

  localparam int c_lanes = DATA_W / 32;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } t_state;

  t_state              r_state;
  t_state              w_next;
  logic [1:0]          r_mode;
  logic [ADDR_W-1:0]   r_base;
  logic [23:0]         r_count;
  logic [31:0]         r_seed;
  logic [23:0]         r_issued;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   r_exp_addr;
  logic [3:0]          r_outst;

  logic w_start_ok, w_en_acc, w_wr_acc, w_rd_acc, w_idle_req, w_all_issued;
  logic w_issue_wr, w_issue_rd, w_rd_valid, w_rd_match;

  function automatic logic [DATA_W-1:0] f_pattern(input logic [ADDR_W-1:0] addr,
                                                  input logic [31:0] seed);
    logic [DATA_W-1:0] v;
    logic [31:0]       b;
    b = 32'(addr) ^ seed;
    v = '0;
    for (int i = 0; i < c_lanes; i++) v[i*32 +: 32] = b + 32'(i);
    return v;
  endfunction

  assign r_app_wdf_end  = r_app_wdf_wren;
  assign r_app_wdf_mask = '0;

  assign w_start_ok   = w_start && w_calib && (w_mode != 2'd3) &&
                        (r_state == S_IDLE || r_state == S_DONE);
  assign w_en_acc     = r_app_en && w_app_rdy;
  assign w_wr_acc     = r_app_wdf_wren && w_app_wdf_rdy;
  assign w_rd_acc     = w_en_acc && (r_app_cmd == 3'b001);
  assign w_idle_req   = !r_app_en && !r_app_wdf_wren;
  assign w_all_issued = (r_issued == r_count);
  assign w_issue_wr   = (r_state == S_WRITE) && w_calib && w_idle_req && !w_all_issued;
  assign w_issue_rd   = (r_state == S_READ) && w_calib && !r_app_en && !w_all_issued &&
                        (r_outst < 4'(MAX_OUT));
  assign w_rd_valid   = w_app_rd_data_valid && (r_state == S_READ || r_state == S_DRAIN);
  assign w_rd_match   = (w_app_rd_data == f_pattern(r_exp_addr, r_seed));

  always_ff @(posedge w_clk) begin
    if (w_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Transitions are frozen while calibration is low; handshakes still complete.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_start_ok) begin
          if (w_count == 24'd0)    w_next = S_DONE;
          else if (w_mode == 2'd1) w_next = S_READ;
          else                     w_next = S_WRITE;
        end
      end
      S_WRITE: begin
        if (w_calib && w_idle_req && w_all_issued)
          w_next = (r_mode == 2'd2) ? S_READ : S_DONE;
      end
      S_READ: begin
        if (w_calib && !r_app_en && w_all_issued) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_calib && r_outst == 4'd0) w_next = S_DONE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_mode           <= '0;
      r_base           <= '0;
      r_count          <= '0;
      r_seed           <= '0;
      r_issued         <= '0;
      r_addr           <= '0;
      r_exp_addr       <= '0;
      r_outst          <= '0;
      r_app_addr       <= '0;
      r_app_cmd        <= 3'b000;
      r_app_en         <= 1'b0;
      r_app_wdf_data   <= '0;
      r_app_wdf_wren   <= 1'b0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_err_cnt        <= '0;
      r_first_err_addr <= '0;
      r_sum            <= '0;
    end else if (w_start_ok) begin
      r_mode           <= w_mode;
      r_base           <= w_base;
      r_count          <= w_count;
      r_seed           <= w_seed;
      r_issued         <= '0;
      r_addr           <= w_base;
      r_exp_addr       <= w_base;
      r_outst          <= '0;
      r_err_cnt        <= '0;
      r_first_err_addr <= '0;
      r_sum            <= '0;
      r_busy           <= (w_count != 24'd0);
      r_done           <= (w_count == 24'd0);
    end else begin
      if (w_en_acc) r_app_en       <= 1'b0;
      if (w_wr_acc) r_app_wdf_wren <= 1'b0;

      if (w_issue_wr) begin
        r_app_en       <= 1'b1;
        r_app_wdf_wren <= 1'b1;
        r_app_cmd      <= 3'b000;
        r_app_addr     <= r_addr;
        r_app_wdf_data <= f_pattern(r_addr, r_seed);
        r_addr         <= r_addr + ADDR_W'(STEP);
        r_issued       <= r_issued + 24'd1;
      end

      if (w_issue_rd) begin
        r_app_en   <= 1'b1;
        r_app_cmd  <= 3'b001;
        r_app_addr <= r_addr;
        r_addr     <= r_addr + ADDR_W'(STEP);
        r_issued   <= r_issued + 24'd1;
      end

      // Verify pass of write-then-verify restarts the walk from the base.
      if (r_state == S_WRITE && w_next == S_READ) begin
        r_addr     <= r_base;
        r_exp_addr <= r_base;
        r_issued   <= '0;
      end

      if (w_rd_acc && !(w_rd_valid && r_outst != 4'd0)) r_outst <= r_outst + 4'd1;
      else if (!w_rd_acc && w_rd_valid && r_outst != 4'd0) r_outst <= r_outst - 4'd1;

      if (w_rd_valid) begin
        r_sum      <= r_sum + w_app_rd_data[31:0];
        r_exp_addr <= r_exp_addr + ADDR_W'(STEP);
        if (!w_rd_match) begin
          if (r_err_cnt != 32'hFFFF_FFFF) r_err_cnt <= r_err_cnt + 32'd1;
          if (r_err_cnt == 32'd0)         r_first_err_addr <= r_exp_addr;
        end
      end

      if (w_next == S_DONE && r_state != S_DONE) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_m_dram_tester.sv
`default_nettype none
// ============================================================================
// Module : tb_m_dram_tester
// Brief  : Scoreboard bench for m_dram_tester with a latency-3 memory model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_m_dram_tester;
  localparam int AW = 27;
  localparam int DW = 128;

  logic          w_clk = 1'b0;
  logic          w_rst = 1'b1;
  logic          w_calib = 1'b0;
  logic          w_start = 1'b0;
  logic [1:0]    w_mode = '0;
  logic [AW-1:0] w_base = '0;
  logic [23:0]   w_count = '0;
  logic [31:0]   w_seed = '0;
  logic          w_app_rdy = 1'b1;
  logic          w_app_wdf_rdy = 1'b1;
  logic          w_app_rd_data_valid = 1'b0;
  logic [DW-1:0] w_app_rd_data = '0;
  logic [AW-1:0] r_app_addr;
  logic [2:0]    r_app_cmd;
  logic          r_app_en;
  logic [DW-1:0] r_app_wdf_data;
  logic          r_app_wdf_wren;
  logic          r_app_wdf_end;
  logic [DW/8-1:0] r_app_wdf_mask;
  logic          r_busy;
  logic          r_done;
  logic [31:0]   r_err_cnt;
  logic [AW-1:0] r_first_err_addr;
  logic [31:0]   r_sum;

  m_dram_tester #(.ADDR_W(AW), .DATA_W(DW), .STEP(8), .MAX_OUT(4)) u_dut (
    .w_clk(w_clk), .w_rst(w_rst), .w_calib(w_calib), .w_start(w_start),
    .w_mode(w_mode), .w_base(w_base), .w_count(w_count), .w_seed(w_seed),
    .r_app_addr(r_app_addr), .r_app_cmd(r_app_cmd), .r_app_en(r_app_en),
    .r_app_wdf_data(r_app_wdf_data), .r_app_wdf_wren(r_app_wdf_wren),
    .r_app_wdf_end(r_app_wdf_end), .r_app_wdf_mask(r_app_wdf_mask),
    .w_app_rdy(w_app_rdy), .w_app_wdf_rdy(w_app_wdf_rdy),
    .w_app_rd_data_valid(w_app_rd_data_valid), .w_app_rd_data(w_app_rd_data),
    .r_busy(r_busy), .r_done(r_done), .r_err_cnt(r_err_cnt),
    .r_first_err_addr(r_first_err_addr), .r_sum(r_sum)
  );

  always #5 w_clk = ~w_clk;

  typedef struct packed { logic [2:0] cmd; logic [AW-1:0] addr; } t_cmd;
  typedef struct packed { int unsigned due; logic [DW-1:0] data; } t_rsp;

  t_cmd          exp_cmd_q[$];
  logic [DW-1:0] exp_wd_q[$];
  t_rsp          rsp_q[$];
  logic [AW-1:0] waddr_q[$];
  logic [DW-1:0] wdata_q[$];
  logic [DW-1:0] mem [logic [AW-1:0]];

  int n_chk = 0;
  int n_pass = 0;
  int n_cmd_acc = 0;
  int n_wr_acc = 0;
  int n_en_hi = 0;
  int outst = 0;
  int max_outst = 0;
  int unsigned cyc = 0;
  logic bp = 1'b0;
  logic chk_en = 1'b1;
  logic flush = 1'b0;
  logic flip_en = 1'b0;
  logic [AW-1:0] flip_addr = '0;
  logic [31:0]   pre_seed = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [DW-1:0] f_pat(input logic [AW-1:0] a, input logic [31:0] s);
    logic [DW-1:0] v;
    logic [31:0]   b;
    b = {5'b0, a} ^ s;
    v = '0;
    for (int i = 0; i < DW/32; i++) v[i*32 +: 32] = b + 32'(i);
    return v;
  endfunction

  function automatic logic [DW-1:0] f_mem_rd(input logic [AW-1:0] a);
    logic [DW-1:0] d;
    if (mem.exists(a)) d = mem[a];
    else               d = f_pat(a, pre_seed);
    if (flip_en && a == flip_addr) d[0] = ~d[0];
    return d;
  endfunction

  // Ready backpressure, changed just after each active edge.
  always @(posedge w_clk) begin
    #1;
    if (bp) begin
      w_app_rdy     = 1'($urandom_range(0, 1));
      w_app_wdf_rdy = 1'($urandom_range(0, 1));
    end else begin
      w_app_rdy     = 1'b1;
      w_app_wdf_rdy = 1'b1;
    end
  end

  // Monitor + memory model: handshakes seen here complete on the next edge.
  always @(negedge w_clk) begin
    cyc++;
    if (r_app_en) n_en_hi++;
    if (flush) begin
      rsp_q.delete();
      waddr_q.delete();
      wdata_q.delete();
      outst = 0;
      w_app_rd_data_valid = 1'b0;
      w_app_rd_data = '0;
    end else begin
      if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
        t_rsp r;
        r = rsp_q.pop_front();
        w_app_rd_data_valid = 1'b1;
        w_app_rd_data = r.data;
        outst--;
      end else begin
        w_app_rd_data_valid = 1'b0;
        w_app_rd_data = '0;
      end
      if (r_app_en && w_app_rdy) begin
        n_cmd_acc++;
        if (chk_en) begin
          if (exp_cmd_q.size() == 0) chk("extra_cmd", {r_app_cmd, r_app_addr}, '0);
          else begin
            t_cmd e;
            e = exp_cmd_q.pop_front();
            chk("cmd_addr", {r_app_cmd, r_app_addr}, {e.cmd, e.addr});
          end
        end
        if (r_app_cmd == 3'b001) begin
          rsp_q.push_back('{due: cyc + 3, data: f_mem_rd(r_app_addr)});
          outst++;
          if (outst > max_outst) max_outst = outst;
        end else begin
          waddr_q.push_back(r_app_addr);
        end
      end
      if (r_app_wdf_wren && w_app_wdf_rdy) begin
        n_wr_acc++;
        if (chk_en) begin
          if (exp_wd_q.size() == 0) chk("extra_wdata", r_app_wdf_data, '0);
          else chk("wdata", r_app_wdf_data, exp_wd_q.pop_front());
        end
        wdata_q.push_back(r_app_wdf_data);
      end
      while (waddr_q.size() > 0 && wdata_q.size() > 0)
        mem[waddr_q.pop_front()] = wdata_q.pop_front();
    end
  end

  task automatic push_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_cmd_q.push_back('{cmd: 3'b000, addr: a});
    exp_wd_q.push_back(d);
  endtask

  task automatic push_rd(input logic [AW-1:0] a);
    exp_cmd_q.push_back('{cmd: 3'b001, addr: a});
  endtask

  task automatic run_test(input logic [1:0] m, input logic [AW-1:0] b, input logic [23:0] c,
                          input logic [31:0] s, output int waited);
    @(negedge w_clk);
    w_mode = m; w_base = b; w_count = c; w_seed = s; w_start = 1'b1;
    @(negedge w_clk);
    w_start = 1'b0;
    waited = 0;
    while (!r_done && waited < 4000) begin
      @(negedge w_clk);
      waited++;
    end
    chk("done_reached", {r_done, r_busy}, 2'b10);
    chk("cmd_queue_drained", 128'(exp_cmd_q.size()), 0);
    chk("wdata_queue_drained", 128'(exp_wd_q.size()), 0);
  endtask

  initial begin
    int w, acc0, wr0, en0;
    logic [31:0] s_exp;
    logic [AW-1:0] a;
    logic [DW-1:0] d;

    repeat (3) @(negedge w_clk);
    chk("reset_state", {r_busy, r_done, r_app_en, r_app_wdf_wren, r_app_cmd, r_app_addr,
                        r_err_cnt, r_sum, r_app_wdf_mask}, '0);
    w_rst = 1'b0;
    @(negedge w_clk);
    w_calib = 1'b1;

    // Plain write, hand-computed lanes.
    push_wr(27'd0,  {32'h3, 32'h2, 32'h1, 32'h0});
    push_wr(27'd8,  {32'hB, 32'hA, 32'h9, 32'h8});
    push_wr(27'd16, {32'h13, 32'h12, 32'h11, 32'h10});
    push_wr(27'd24, {32'h1B, 32'h1A, 32'h19, 32'h18});
    wr0 = n_wr_acc;
    run_test(2'd0, 27'd0, 24'd4, 32'h0, w);
    chk("wr_count_t1", 128'(n_wr_acc - wr0), 4);

    // Write-then-verify.
    s_exp = '0;
    max_outst = 0;
    for (int k = 0; k < 16; k++) begin
      a = 27'h1000 + 27'(8 * k);
      push_wr(a, f_pat(a, 32'hA5A5A5A5));
    end
    for (int k = 0; k < 16; k++) begin
      a = 27'h1000 + 27'(8 * k);
      push_rd(a);
      s_exp = s_exp + (32'(a) ^ 32'hA5A5A5A5);
    end
    run_test(2'd2, 27'h1000, 24'd16, 32'hA5A5A5A5, w);
    chk("wv_err_cnt", r_err_cnt, 0);
    chk("wv_sum", r_sum, s_exp);
    chk("wv_max_outst_le4", 128'(max_outst <= 4), 1);

    // Read-verify against a preloaded memory with burst 5 corrupted.
    pre_seed = 32'h12345678;
    flip_addr = 27'h2028;
    flip_en = 1'b1;
    s_exp = '0;
    for (int k = 0; k < 8; k++) begin
      a = 27'h2000 + 27'(8 * k);
      push_rd(a);
      s_exp = s_exp + ((32'(a) ^ 32'h12345678) ^ ((k == 5) ? 32'd1 : 32'd0));
    end
    run_test(2'd1, 27'h2000, 24'd8, 32'h12345678, w);
    chk("rv_err_cnt", r_err_cnt, 1);
    chk("rv_first_err_addr", r_first_err_addr, 27'h2028);
    chk("rv_sum", r_sum, s_exp);
    flip_en = 1'b0;

    // Random independent backpressure on both ready lines.
    bp = 1'b1;
    for (int k = 0; k < 10; k++) begin
      a = 27'h300 + 27'(8 * k);
      push_wr(a, f_pat(a, 32'h0F0F0F0F));
    end
    acc0 = n_cmd_acc;
    wr0 = n_wr_acc;
    run_test(2'd0, 27'h300, 24'd10, 32'h0F0F0F0F, w);
    chk("bp_cmd_count", 128'(n_cmd_acc - acc0), 10);
    chk("bp_wr_count", 128'(n_wr_acc - wr0), 10);
    bp = 1'b0;

    // Address wrap-around.
    push_wr(27'h7FFFFF0, f_pat(27'h7FFFFF0, 32'h0));
    push_wr(27'h7FFFFF8, f_pat(27'h7FFFFF8, 32'h0));
    push_wr(27'h0000000, {32'h3, 32'h2, 32'h1, 32'h0});
    push_wr(27'h0000008, {32'hB, 32'hA, 32'h9, 32'h8});
    run_test(2'd0, 27'h7FFFFF0, 24'd4, 32'h0, w);

    // Zero-length run.
    en0 = n_en_hi;
    run_test(2'd1, 27'h40, 24'd0, 32'h0, w);
    chk("cnt0_latency", 128'(w), 0);
    repeat (3) @(negedge w_clk);
    chk("cnt0_no_app_en", 128'(n_en_hi - en0), 0);

    // Reset in the middle of a read pass.
    chk_en = 1'b0;
    run_test_start: begin
      @(negedge w_clk);
      w_mode = 2'd1; w_base = 27'd0; w_count = 24'd16; w_seed = 32'h0; w_start = 1'b1;
      @(negedge w_clk);
      w_start = 1'b0;
      repeat (6) @(negedge w_clk);
    end
    chk("mid_read_busy", {r_busy, r_done}, 2'b10);
    w_rst = 1'b1;
    flush = 1'b1;
    repeat (2) @(negedge w_clk);
    w_rst = 1'b0;
    chk("reset_mid_read", {r_busy, r_done, r_app_en, r_app_wdf_wren, r_app_cmd, r_app_addr,
                           r_err_cnt, r_sum, r_first_err_addr}, '0);
    @(negedge w_clk);
    flush = 1'b0;
    repeat (3) @(negedge w_clk);
    chk("idle_after_reset", {r_busy, r_done, r_app_en}, 3'b000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/m_dram_tester.md
M_DRAM_TESTER -- requirements
Module: m_dram_tester

Interface
REQ-001 SHALL have parameter ADDR_W, default 27, MIG app_addr width.
REQ-002 SHALL have parameter DATA_W, default 128, app data width, multiple of 32.
REQ-003 SHALL have parameter STEP, default 8, address increment per burst.
REQ-004 SHALL have parameter MAX_OUT, default 4, maximum outstanding reads (1..15).
REQ-005 SHALL use one clock and a synchronous, active-high reset: w_clk (in, 1, MIG ui_clk) and w_rst (in, 1, reset); no other clock or reset.
REQ-006 SHALL have these control ports: w_calib (in, 1, init_calib_complete); w_start (in, 1, start pulse); w_mode (in, 2, 0=write, 1=read-verify, 2=write-then-verify, 3=reserved/ignored); w_base (in, ADDR_W, first address); w_count (in, 24, number of bursts); w_seed (in, 32, pattern seed).
REQ-007 SHALL have these MIG-facing ports: r_app_addr (out, ADDR_W); r_app_cmd (out, 3, 000 write, 001 read); r_app_en (out, 1); r_app_wdf_data (out, DATA_W); r_app_wdf_wren and r_app_wdf_end (out, 1, identical); r_app_wdf_mask (out, DATA_W/8, always 0); w_app_rdy, w_app_wdf_rdy, w_app_rd_data_valid (in, 1); w_app_rd_data (in, DATA_W).
REQ-008 SHALL have these status ports: r_busy (out, 1); r_done (out, 1, sticky until next start); r_err_cnt (out, 32, saturating); r_first_err_addr (out, ADDR_W); r_sum (out, 32, sum of low 32 bits of read data).

Function
REQ-009 SHALL implement states IDLE, WRITE, READ, DRAIN, DONE.
REQ-010 SHALL accept w_start only in IDLE or DONE with w_calib=1 and w_mode!=3; on acceptance it latches base/count/seed/mode, clears r_done, r_err_cnt, r_sum and r_first_err_addr, and sets r_busy.
REQ-011 SHALL go directly to DONE on the next cycle, issuing no command, when the latched count is 0.
REQ-012 SHALL define burst k's address as (base + k*STEP) mod 2^ADDR_W; wrap-around is silent.
REQ-013 SHALL define pattern lane i (32 bits, i=0..DATA_W/32-1) of burst address A as ({A zero-extended to 32} XOR seed) + i.
REQ-014 WRITE: for each burst, SHALL assert r_app_en with cmd 000 and r_app_wdf_wren with the pattern together; r_app_en drops in the cycle after w_app_rdy=1; wren drops in the cycle after w_app_wdf_rdy=1; the two are accepted independently; the next burst starts only after both are accepted; one cycle per burst minimum is not required.
REQ-015 WRITE completion SHALL enter READ when mode=2 (address reset to base), else DONE.
REQ-016 READ: SHALL issue cmd 001 bursts while outstanding<MAX_OUT, with r_app_en held until w_app_rdy; the outstanding count increments on acceptance and decrements on w_app_rd_data_valid, and a simultaneous accept and valid leaves it unchanged.
REQ-017 SHALL compare read data in issue order against the pattern of a separate expected-address counter; on mismatch r_err_cnt increments (saturates at FFFFFFFF), and the first mismatch latches r_first_err_addr.
REQ-018 SHALL add w_app_rd_data[31:0] to r_sum modulo 2^32 on every valid beat.
REQ-019 After all reads are issued, SHALL enter DRAIN and wait for outstanding=0, then DONE.
REQ-020 SHALL ignore w_app_rd_data_valid in any state other than READ or DRAIN.
REQ-021 SHALL enter DONE with r_busy=0 and r_done=1; any command in flight has been accepted before leaving WRITE or READ.
REQ-022 SHALL freeze the FSM while w_calib=0 (no new r_app_en assertion) while holding already-asserted requests.

Reset
REQ-023 On w_rst SHALL enter IDLE, with all outputs 0, r_app_cmd=000, outstanding=0 and the expected-address counter at 0; reset mid-transfer abandons it without completion.

Verification
REQ-024 Write: mode=0, base=0, count=4, seed=0, rdy always 1 -> four writes at addresses 0,8,16,24; lane0 of address 8 = 0x00000008, lane3 = 0x0000000B; done=1.
REQ-025 Write-then-verify: mode=2, count=16, seed=A5A5A5A5, model memory returns reads with 3-cycle latency -> err_cnt=0, at most 4 outstanding at any time, and sum equals the sum of the lane0 values.
REQ-026 Corrupted read: mode=1, model memory flips bit 0 of burst 5 -> err_cnt=1, first_err_addr=base+40.
REQ-027 Backpressure: app_rdy and wdf_rdy toggled randomly and independently -> no command lost or duplicated; the number of accepted writes equals count.
REQ-028 Wrap-around and edges: base=2^27-16, count=4 -> addresses 2^27-16, 2^27-8, 0, 8; count=0 -> done after one cycle with no app_en; reset asserted in READ -> IDLE, outputs 0.
